// File: rtl/mult_hilo_unit.sv
// Iterative unsigned shift-add multiplier with HI/LO result registers.
// It holds the pipeline through stall while a product is still being formed.
//
//    state | meaning
//    ------+----------------------------------------------------------
//    IDLE  | waiting for mult_enable; HI/LO hold the last product
//    RUN   | one partial-product step per cycle, WIDTH cycles in all
//    DONE  | HI/LO were updated on the previous edge; a restart is allowed here
module mult_hilo_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mult_enable,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             sfmux_high,
   input  logic             sf2reg,
   output logic [WIDTH-1:0] sf_out,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplr;
   logic [2*WIDTH-1:0] sum;
   logic               busy_q;
   logic               done_q;

   always_comb begin
      sum = acc;
      if (mplr[0]) sum = acc + mcand;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         hi     <= '0;
         lo     <= '0;
         count  <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplr   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (mult_enable) begin
                  mcand  <= {{WIDTH{1'b0}}, rs_data};
                  mplr   <= rt_data;
                  acc    <= '0;
                  count  <= COUNT_INIT;
                  state  <= RUN;
                  busy_q <= 1'b1;
               end
            end
            RUN: begin
               acc   <= sum;
               mcand <= mcand << 1;
               mplr  <= mplr >> 1;
               // HI and LO change together, only on the last step.
               if (count == '0) begin
                  hi     <= sum[2*WIDTH-1:WIDTH];
                  lo     <= sum[WIDTH-1:0];
                  state  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end else begin
                  count <= count - 1'b1;
               end
            end
            DONE: begin
               done_q <= 1'b0;
               if (mult_enable) begin
                  mcand  <= {{WIDTH{1'b0}}, rs_data};
                  mplr   <= rt_data;
                  acc    <= '0;
                  count  <= COUNT_INIT;
                  state  <= RUN;
                  busy_q <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign stall  = busy_q & (sf2reg | mult_enable);
   assign sf_out = sfmux_high ? hi : lo;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed bench for mult_hilo_unit: products, HI/LO interlock, abort on reset, back-to-back restart.
module tb_mult_hilo_unit;

   logic        clk;
   logic        rst_n;
   logic        mult_enable;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        sfmux_high;
   logic        sf2reg;
   logic [31:0] sf_out;
   logic        busy;
   logic        done;
   logic        stall;

   int errors = 0;
   int checks = 0;
   int ncyc;
   bit seen;

   mult_hilo_unit #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mult_enable (mult_enable),
      .rs_data     (rs_data),
      .rt_data     (rt_data),
      .sfmux_high  (sfmux_high),
      .sf2reg      (sf2reg),
      .sf_out      (sf_out),
      .busy        (busy),
      .done        (done),
      .stall       (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      sfmux_high = 1'b1;
      #1;
      chk({tag, "_hi"}, {32'h0, sf_out}, {32'h0, exp_hi});
      sfmux_high = 1'b0;
      #1;
      chk({tag, "_lo"}, {32'h0, sf_out}, {32'h0, exp_lo});
   endtask

   task automatic start_mult(input logic [31:0] a, input logic [31:0] b);
      rs_data     = a;
      rt_data     = b;
      mult_enable = 1'b1;
      tick();
      mult_enable = 1'b0;
   endtask

   // Counts the cycles busy stays high; leaves the bench in the cycle after busy drops.
   task automatic run_to_done(output int n);
      n = 0;
      while (busy && n < 100) begin
         n++;
         tick();
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      mult_enable = 1'b0;
      rs_data     = '0;
      rt_data     = '0;
      sfmux_high  = 1'b0;
      sf2reg      = 1'b0;
      #1;
      chk("rst_busy", {63'h0, busy}, 64'h0);
      chk("rst_done", {63'h0, done}, 64'h0);
      chk("rst_stall", {63'h0, stall}, 64'h0);
      chk_hilo("rst", 32'h0, 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // 3*5 with cycle count and a single done pulse
      start_mult(32'd3, 32'd5);
      chk("t1_busy_start", {63'h0, busy}, 64'h1);
      run_to_done(ncyc);
      chk("t1_busy_cycles", 64'(ncyc), 64'd32);
      chk("t1_done", {63'h0, done}, 64'h1);
      chk_hilo("t1", 32'h0, 32'h0000000F);
      tick();
      chk("t1_done_once", {63'h0, done}, 64'h0);
      chk("t1_idle_busy", {63'h0, busy}, 64'h0);

      // extreme operands
      start_mult(32'hFFFFFFFF, 32'hFFFFFFFF);
      run_to_done(ncyc);
      chk_hilo("t2a", 32'hFFFFFFFE, 32'h00000001);
      tick();
      start_mult(32'h80000000, 32'd2);
      run_to_done(ncyc);
      chk_hilo("t2b", 32'h00000001, 32'h0);
      tick();

      // mfhi during RUN: stall holds, old HI visible until DONE
      start_mult(32'h12345678, 32'h00000100);
      repeat (4) tick();
      sf2reg     = 1'b1;
      sfmux_high = 1'b1;
      ncyc       = 0;
      while (busy && ncyc < 100) begin
         #1;
         chk("t3_stall_run", {63'h0, stall}, 64'h1);
         chk("t3_old_hi", {32'h0, sf_out}, 64'h1);
         ncyc++;
         tick();
      end
      chk("t3_run_left", 64'(ncyc), 64'd28);
      chk("t3_done", {63'h0, done}, 64'h1);
      chk("t3_stall_done", {63'h0, stall}, 64'h0);
      chk("t3_new_hi", {32'h0, sf_out}, 64'h12);
      sf2reg = 1'b0;
      chk_hilo("t3", 32'h00000012, 32'h34567800);
      tick();

      // reset mid-RUN aborts everything
      start_mult(32'd2, 32'd2);
      run_to_done(ncyc);
      chk_hilo("t4_pre", 32'h0, 32'h4);
      tick();
      start_mult(32'd7, 32'd9);
      repeat (9) tick();
      rst_n = 1'b0;
      #1;
      chk("t4_busy", {63'h0, busy}, 64'h0);
      chk("t4_done", {63'h0, done}, 64'h0);
      chk_hilo("t4", 32'h0, 32'h0);
      tick();
      rst_n = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done || busy) seen = 1'b1;
      end
      chk("t4_no_done", {63'h0, seen}, 64'h0);
      chk_hilo("t4_after", 32'h0, 32'h0);

      // back-to-back restart from DONE
      start_mult(32'd5, 32'd5);
      run_to_done(ncyc);
      chk("t5_first_done", {63'h0, done}, 64'h1);
      chk_hilo("t5_first", 32'h0, 32'd25);
      start_mult(32'd6, 32'd7);
      chk("t5_restart_busy", {63'h0, busy}, 64'h1);
      run_to_done(ncyc);
      chk("t5_busy_cycles", 64'(ncyc), 64'd32);
      chk("t5_done", {63'h0, done}, 64'h1);
      chk_hilo("t5", 32'h0, 32'h0000002A);
      tick();

      // mult_enable mid-RUN is ignored but stalls
      start_mult(32'h00001000, 32'h00001000);
      repeat (9) tick();
      rs_data     = 32'hFFFFFFFF;
      rt_data     = 32'd3;
      mult_enable = 1'b1;
      #1;
      chk("t6_stall", {63'h0, stall}, 64'h1);
      tick();
      mult_enable = 1'b0;
      rs_data     = 32'hDEADBEEF;
      run_to_done(ncyc);
      chk("t6_run_left", 64'(ncyc), 64'd22);
      chk("t6_done", {63'h0, done}, 64'h1);
      chk_hilo("t6", 32'h0, 32'h01000000);
      tick();
      chk("t6_no_restart", {63'h0, busy}, 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
